// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter: write codes, FSM states
// and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'd0,
    MW_WORD = 2'd1,
    MW_DMA  = 2'd2,
    MW_BYTE = 2'd3
  } mw_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: CPU and DMA request/grant/done plus shared read data.
interface mem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_done;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_done;

  logic [31:0] rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output cpu_gnt, cpu_done, dma_gnt, dma_done, rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  cpu_gnt, cpu_done, dma_gnt, dma_done, rdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational two-port winner selection: bounded DMA lock first, then
// round-robin on a tie, otherwise the lone requester.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic       dma_lock,
  input  logic       last_port,
  input  logic [7:0] burst_cnt,
  output logic       any_req,
  output logic       winner
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  always_comb begin
    any_req = cpu_req | dma_req;
    winner  = PORT_CPU;
    if (dma_lock && dma_req && (burst_cnt < MAX_B)) begin
      winner = PORT_DMA;
    end else if (cpu_req && dma_req) begin
      winner = (last_port == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (dma_req) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and DMA share one memory bus; each access holds
// the strobes for MEM_LAT cycles and ends with a one-cycle done pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave req_if,
  output logic         Memread,
  output logic [1:0]   Memwrite,
  output logic [31:0]  Addr,
  inout  wire  [31:0]  BUS
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);
  localparam logic [7:0] MAX_B    = 8'(MAX_BURST);

  state_t      state_reg, state_next;
  mw_code_t    mw_reg, mw_next;
  logic [2:0]  lat_reg, lat_next;
  logic [7:0]  burst_reg, burst_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        last_reg, last_next;
  logic        rd_reg, rd_next;
  logic        cpu_gnt_reg, cpu_gnt_next;
  logic        dma_gnt_reg, dma_gnt_next;
  logic        cpu_done_reg, cpu_done_next;
  logic        dma_done_reg, dma_done_next;
  logic        any_req;
  logic        winner;

  rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .cpu_req   (req_if.cpu_req),
    .dma_req   (req_if.dma_req),
    .dma_lock  (req_if.dma_lock),
    .last_port (last_reg),
    .burst_cnt (burst_reg),
    .any_req   (any_req),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      mw_reg       <= MW_NONE;
      lat_reg      <= '0;
      burst_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      last_reg     <= PORT_DMA;
      rd_reg       <= 1'b0;
      cpu_gnt_reg  <= 1'b0;
      dma_gnt_reg  <= 1'b0;
      cpu_done_reg <= 1'b0;
      dma_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mw_reg       <= mw_next;
      lat_reg      <= lat_next;
      burst_reg    <= burst_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      last_reg     <= last_next;
      rd_reg       <= rd_next;
      cpu_gnt_reg  <= cpu_gnt_next;
      dma_gnt_reg  <= dma_gnt_next;
      cpu_done_reg <= cpu_done_next;
      dma_done_reg <= dma_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mw_next       = mw_reg;
    lat_next      = lat_reg;
    burst_next    = burst_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    last_next     = last_reg;
    rd_next       = rd_reg;
    cpu_gnt_next  = cpu_gnt_reg;
    dma_gnt_next  = dma_gnt_reg;
    cpu_done_next = 1'b0;
    dma_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!req_if.dma_lock) burst_next = '0;
        if (any_req) begin
          last_next  = winner;
          lat_next   = LAT_LOAD;
          state_next = ST_ACCESS;
          if (winner == PORT_CPU) begin
            addr_next    = req_if.cpu_addr;
            wdata_next   = req_if.cpu_wdata;
            rd_next      = !req_if.cpu_we;
            mw_next      = !req_if.cpu_we ? MW_NONE : (req_if.cpu_byte ? MW_BYTE : MW_WORD);
            cpu_gnt_next = 1'b1;
            burst_next   = '0;
          end else begin
            addr_next    = req_if.dma_addr;
            wdata_next   = req_if.dma_wdata;
            rd_next      = !req_if.dma_we;
            mw_next      = req_if.dma_we ? MW_DMA : MW_NONE;
            dma_gnt_next = 1'b1;
            // Only grants that actually make the CPU wait count against the lock budget.
            if (req_if.dma_lock && req_if.cpu_req && (burst_reg < MAX_B))
              burst_next = 8'(burst_reg + 8'd1);
          end
        end
      end
      ST_ACCESS: begin
        if (lat_reg == 3'd0) begin
          state_next    = ST_DONE;
          rdata_next    = rd_reg ? BUS : rdata_reg;
          rd_next       = 1'b0;
          mw_next       = MW_NONE;
          cpu_gnt_next  = 1'b0;
          dma_gnt_next  = 1'b0;
          cpu_done_next = (last_reg == PORT_CPU);
          dma_done_next = (last_reg == PORT_DMA);
        end else begin
          lat_next = lat_reg - 3'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign Memread         = rd_reg;
  assign Memwrite        = mw_reg;
  assign Addr            = addr_reg;
  assign BUS             = (mw_reg != MW_NONE) ? wdata_reg : 32'bz;
  assign req_if.cpu_gnt  = cpu_gnt_reg;
  assign req_if.dma_gnt  = dma_gnt_reg;
  assign req_if.cpu_done = cpu_done_reg;
  assign req_if.dma_done = dma_done_reg;
  assign req_if.rdata    = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: DUT A (MEM_LAT=1, MAX_BURST=4) for arbitration
// and strobes, DUT B (MEM_LAT=3) for reset during an access.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  mw;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  mem_arbiter_if ifa ();
  mem_arbiter_if ifb ();

  logic        rd_a, rd_b;
  logic [1:0]  mw_a, mw_b;
  logic [31:0] addr_a, addr_b;
  wire  [31:0] bus_a, bus_b;

  // Undriven bus reads as all ones, so high-Z is observable.
  pullup (bus_a);
  pullup (bus_b);

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h12345678;
    return {a[15:0], 16'hA5C3};
  endfunction

  assign bus_a = rd_a ? mem_val(addr_a) : 32'bz;
  assign bus_b = rd_b ? mem_val(addr_b) : 32'bz;

  mem_arbiter #(.MEM_LAT(LAT_A), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_if(ifa), .Memread(rd_a), .Memwrite(mw_a), .Addr(addr_a), .BUS(bus_a)
  );

  mem_arbiter #(.MEM_LAT(LAT_B), .MAX_BURST(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_if(ifb), .Memread(rd_b), .Memwrite(mw_b), .Addr(addr_b), .BUS(bus_b)
  );

  int checks = 0;
  int failures = 0;
  acc_t  acc_q[$];
  done_t done_q[$];
  int b_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: access start/length/bus and done pulses on DUT A against the queues.
  logic act_prev = 1'b0;
  int   act_len  = 0;
  always @(negedge clk) begin
    logic  active;
    acc_t  e;
    done_t d;
    active = rd_a || (mw_a != 2'd0);
    if (rst_a) begin
      if (active && !act_prev) begin
        act_len = 1;
        if (acc_q.size() == 0) begin
          check("acc_unexpected", 32'd1, 32'd0);
        end else begin
          e = acc_q.pop_front();
          $display("access port=%0d addr=%h rd=%0d mw=%0d bus=%h", e.port, addr_a, rd_a, mw_a, bus_a);
          check("acc_addr", addr_a, e.addr);
          check("acc_rd", 32'(rd_a), 32'(e.rd));
          check("acc_mw", 32'(mw_a), 32'(e.mw));
          check("acc_gnt", {30'd0, ifa.dma_gnt, ifa.cpu_gnt}, e.port ? 32'd2 : 32'd1);
          if (e.mw != 2'd0) check("acc_bus", bus_a, e.wdata);
        end
      end else if (active) begin
        act_len++;
      end else if (act_prev) begin
        check("acc_len", 32'(act_len), 32'(LAT_A));
        check("bus_hiz", bus_a, 32'hFFFFFFFF);
      end
      if (ifa.cpu_done || ifa.dma_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          $display("done port=%0d rdata=%h", d.port, ifa.rdata);
          check("done_port", {30'd0, ifa.dma_done, ifa.cpu_done}, d.port ? 32'd2 : 32'd1);
          check("done_rdata", ifa.rdata, d.rdata);
          check("done_gnt_clear", {30'd0, ifa.dma_gnt, ifa.cpu_gnt}, 32'd0);
        end
      end
    end
    act_prev = active;
  end

  always @(negedge clk) begin
    if (rst_b && (ifb.cpu_done || ifb.dma_done)) b_done_cnt++;
  end

  task automatic xfer_a(input logic port, input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] exp_mw, input logic [31:0] exp_rdata);
    int n;
    acc_q.push_back(acc_t'{port, addr, !we, exp_mw, wdata});
    done_q.push_back(done_t'{port, exp_rdata});
    if (port == PORT_CPU) begin
      ifa.cpu_we = we; ifa.cpu_byte = byt; ifa.cpu_addr = addr; ifa.cpu_wdata = wdata; ifa.cpu_req = 1'b1;
    end else begin
      ifa.dma_we = we; ifa.dma_addr = addr; ifa.dma_wdata = wdata; ifa.dma_req = 1'b1;
    end
    n = 0;
    while (!(port ? ifa.dma_gnt : ifa.cpu_gnt) && n < 20) begin tick(); n++; end
    check("gnt_wait", 32'(n < 20), 32'd1);
    ifa.cpu_req = 1'b0;
    ifa.dma_req = 1'b0;
    n = 0;
    while (!(port ? ifa.dma_done : ifa.cpu_done) && n < 20) begin tick(); n++; end
    check("done_latency", 32'(n), 32'(LAT_A));
    tick();
    tick();
  endtask

  task automatic wait_grants_a(input int k);
    int   g, n;
    logic prev, cur;
    g = 0; n = 0; prev = 1'b0;
    while (g < k && n < 100) begin
      tick();
      n++;
      cur = ifa.cpu_gnt || ifa.dma_gnt;
      if (cur && !prev) g++;
      prev = cur;
    end
    check("grant_count", 32'(g), 32'(k));
  endtask

  initial begin
    int n;
    ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_byte = 0; ifa.cpu_addr = 0; ifa.cpu_wdata = 0;
    ifa.dma_req = 0; ifa.dma_we = 0; ifa.dma_lock = 0; ifa.dma_addr = 0; ifa.dma_wdata = 0;
    ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_byte = 0; ifb.cpu_addr = 0; ifb.cpu_wdata = 0;
    ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_lock = 0; ifb.dma_addr = 0; ifb.dma_wdata = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    // Reset values must appear before any clock edge.
    check("rst_cpu_gnt", 32'(ifa.cpu_gnt), 32'd0);
    check("rst_dma_gnt", 32'(ifa.dma_gnt), 32'd0);
    check("rst_cpu_done", 32'(ifa.cpu_done), 32'd0);
    check("rst_dma_done", 32'(ifa.dma_done), 32'd0);
    check("rst_rdata", ifa.rdata, 32'd0);
    check("rst_memread", 32'(rd_a), 32'd0);
    check("rst_memwrite", 32'(mw_a), 32'd0);
    check("rst_addr", addr_a, 32'd0);
    check("rst_bus_hiz", bus_a, 32'hFFFFFFFF);
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    xfer_a(PORT_CPU, 1'b0, 1'b0, 32'h10, 32'h0, 2'd0, 32'h12345678);

    // Fresh reset: CPU must win the first tie, then alternation.
    rst_a = 1'b0; tick(); tick(); rst_a = 1'b1; tick();
    acc_q.push_back(acc_t'{PORT_CPU, 32'h30, 1'b1, 2'd0, 32'h0});
    acc_q.push_back(acc_t'{PORT_DMA, 32'h50, 1'b1, 2'd0, 32'h0});
    acc_q.push_back(acc_t'{PORT_CPU, 32'h30, 1'b1, 2'd0, 32'h0});
    done_q.push_back(done_t'{PORT_CPU, 32'h0030A5C3});
    done_q.push_back(done_t'{PORT_DMA, 32'h0050A5C3});
    done_q.push_back(done_t'{PORT_CPU, 32'h0030A5C3});
    ifa.cpu_addr = 32'h30; ifa.cpu_we = 0; ifa.dma_addr = 32'h50; ifa.dma_we = 0; ifa.dma_lock = 0;
    ifa.cpu_req = 1; ifa.dma_req = 1;
    wait_grants_a(3);
    ifa.cpu_req = 0; ifa.dma_req = 0;
    repeat (4) tick();

    // Locked burst with the CPU waiting: 4 DMA grants, then the CPU.
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back(acc_t'{PORT_DMA, 32'h100, 1'b1, 2'd0, 32'h0});
      done_q.push_back(done_t'{PORT_DMA, 32'h0100A5C3});
    end
    acc_q.push_back(acc_t'{PORT_CPU, 32'h60, 1'b1, 2'd0, 32'h0});
    done_q.push_back(done_t'{PORT_CPU, 32'h0060A5C3});
    ifa.cpu_addr = 32'h60; ifa.dma_addr = 32'h100; ifa.dma_lock = 1;
    ifa.cpu_req = 1; ifa.dma_req = 1;
    wait_grants_a(5);
    ifa.cpu_req = 0; ifa.dma_req = 0; ifa.dma_lock = 0;
    repeat (4) tick();

    // Writes leave rdata at the last read value.
    xfer_a(PORT_CPU, 1'b1, 1'b1, 32'h20, 32'h123456AB, 2'd3, 32'h0060A5C3);
    xfer_a(PORT_DMA, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 2'd2, 32'h0060A5C3);
    xfer_a(PORT_CPU, 1'b1, 1'b0, 32'h24, 32'hCAFEF00D, 2'd1, 32'h0060A5C3);
    xfer_a(PORT_DMA, 1'b0, 1'b0, 32'h88, 32'h0, 2'd0, 32'h0088A5C3);

    // DUT B: reset in the middle of a MEM_LAT=3 read.
    ifb.cpu_addr = 32'h70; ifb.cpu_we = 0; ifb.cpu_req = 1;
    n = 0;
    while (!ifb.cpu_gnt && n < 20) begin tick(); n++; end
    check("b_gnt_wait", 32'(n < 20), 32'd1);
    ifb.cpu_req = 0;
    tick();
    check("b_memread_before", 32'(rd_b), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("b_rst_memread", 32'(rd_b), 32'd0);
    check("b_rst_memwrite", 32'(mw_b), 32'd0);
    check("b_rst_addr", addr_b, 32'd0);
    check("b_rst_gnt", {30'd0, ifb.dma_gnt, ifb.cpu_gnt}, 32'd0);
    check("b_rst_done", {30'd0, ifb.dma_done, ifb.cpu_done}, 32'd0);
    check("b_rst_rdata", ifb.rdata, 32'd0);
    check("b_rst_bus_hiz", bus_b, 32'hFFFFFFFF);
    tick(); tick();
    rst_b = 1'b1;
    repeat (6) tick();
    check("b_no_done_after_abort", 32'(b_done_cnt), 32'd0);

    ifb.cpu_addr = 32'h80; ifb.cpu_req = 1;
    n = 0;
    while (!ifb.cpu_gnt && n < 20) begin tick(); n++; end
    check("b_gnt_wait2", 32'(n < 20), 32'd1);
    ifb.cpu_req = 0;
    n = 0;
    while (!ifb.cpu_done && n < 20) begin tick(); n++; end
    $display("b done rdata=%h after %0d cycles", ifb.rdata, n);
    check("b_done_latency", 32'(n), 32'(LAT_B));
    check("b_rdata", ifb.rdata, 32'h0080A5C3);
    repeat (3) tick();
    check("b_done_count", 32'(b_done_cnt), 32'd1);

    check("acc_q_empty", 32'(acc_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
